// File: rtl/ppl_stage_buf.sv
// Elastic pipeline stage carrying PC + instruction, with a one-entry skid register
// so that inReady is registered and never depends combinationally on outReady.
module ppl_stage_buf #(
  parameter int                 PC_W        = 32,
  parameter int                 INST_W      = 32,
  parameter logic [PC_W-1:0]    RESET_PC    = PC_W'(32'h8000_0000),
  parameter logic [INST_W-1:0]  NOP_INST    = '0,
  parameter int                 FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [PC_W-1:0]        pcIn,
  input  logic [INST_W-1:0]      instIn,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [PC_W-1:0]        pcOut,
  output logic [INST_W-1:0]      instOut,
  output logic [1:0]             count,
  output logic [FLUSH_CNT_W-1:0] flushDrops
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [1:0]             count_q;
  logic [PC_W-1:0]        main_pc_q;
  logic [INST_W-1:0]      main_inst_q;
  logic [PC_W-1:0]        skid_pc_q;
  logic [INST_W-1:0]      skid_inst_q;
  logic [FLUSH_CNT_W-1:0] flush_drops_q;
  logic [FLUSH_CNT_W-1:0] flush_drops_d;

  logic                   in_fire;
  logic                   out_fire;
  logic [1:0]             drop_num;
  logic [FLUSH_CNT_W:0]   drop_sum;

  assign in_fire  = inValid & in_ready_q;
  assign out_fire = out_valid_q & outReady;

  // An entry leaving on the flush cycle was delivered, so it is not a drop.
  assign drop_num      = count_q - {1'b0, out_fire};
  assign drop_sum      = {1'b0, flush_drops_q} + (FLUSH_CNT_W+1)'(drop_num);
  assign flush_drops_d = drop_sum[FLUSH_CNT_W] ? '1 : drop_sum[FLUSH_CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      count_q       <= 2'd0;
      main_pc_q     <= RESET_PC;
      main_inst_q   <= NOP_INST;
      skid_pc_q     <= '0;
      skid_inst_q   <= '0;
      flush_drops_q <= '0;
    end else if (flush) begin
      state_q       <= S_EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      count_q       <= 2'd0;
      main_inst_q   <= NOP_INST;
      flush_drops_q <= flush_drops_d;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
            count_q     <= 2'd1;
            main_pc_q   <= pcIn;
            main_inst_q <= instIn;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_pc_q   <= pcIn;
            main_inst_q <= instIn;
          end else if (in_fire) begin
            state_q     <= S_FULL;
            in_ready_q  <= 1'b0;
            count_q     <= 2'd2;
            skid_pc_q   <= pcIn;
            skid_inst_q <= instIn;
          end else if (out_fire) begin
            // pcOut keeps the last delivered PC; only the instruction goes to NOP.
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
            main_inst_q <= NOP_INST;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_q     <= S_ONE;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd1;
            main_pc_q   <= skid_pc_q;
            main_inst_q <= skid_inst_q;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          count_q     <= 2'd0;
          main_inst_q <= NOP_INST;
        end
      endcase
    end
  end

  assign inReady    = in_ready_q;
  assign outValid   = out_valid_q;
  assign count      = count_q;
  assign pcOut      = main_pc_q;
  assign instOut    = main_inst_q;
  assign flushDrops = flush_drops_q;

endmodule

// File: tb/tb_ppl_stage_buf.sv
// Directed bench for ppl_stage_buf: streaming, skid, flush, saturation, async reset.
module tb_ppl_stage_buf;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] pc_in;
  logic [31:0] inst_in;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [1:0]  count;
  logic [7:0]  flush_drops;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_pc_out;
  logic [31:0] s_inst_out;
  logic [1:0]  s_count;
  logic [1:0]  s_flush_drops;

  int checks;
  int errors;

  ppl_stage_buf u_dut (
    .clk        (clk),
    .reset      (rst_n),
    .flush      (flush),
    .inValid    (in_valid),
    .inReady    (in_ready),
    .pcIn       (pc_in),
    .instIn     (inst_in),
    .outValid   (out_valid),
    .outReady   (out_ready),
    .pcOut      (pc_out),
    .instOut    (inst_out),
    .count      (count),
    .flushDrops (flush_drops)
  );

  // Narrow-counter copy driven by identical stimulus, used for saturation.
  ppl_stage_buf #(.FLUSH_CNT_W(2)) u_sat (
    .clk        (clk),
    .reset      (rst_n),
    .flush      (flush),
    .inValid    (in_valid),
    .inReady    (s_in_ready),
    .pcIn       (pc_in),
    .instIn     (inst_in),
    .outValid   (s_out_valid),
    .outReady   (out_ready),
    .pcOut      (s_pc_out),
    .instOut    (s_inst_out),
    .count      (s_count),
    .flushDrops (s_flush_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t vld=%0b rdy=%0b cnt=%0d pc=%h inst=%h drops=%0d",
             $time, out_valid, in_ready, count, pc_out, inst_out, flush_drops);
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid = v;
    pc_in    = pc;
    inst_in  = inst;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    chk("rst_pc",    pc_out,      32'h8000_0000);
    chk("rst_inst",  inst_out,    32'h0);
    chk("rst_vld",   out_valid,   1'b0);
    chk("rst_rdy",   in_ready,    1'b1);
    chk("rst_cnt",   count,       2'd0);
    chk("rst_drops", flush_drops, 8'd0);

    // Streaming at full throughput
    out_ready = 1'b1;
    offer(1'b1, 32'h8000_0000, 32'h1111);
    step();
    chk("st0_vld",  out_valid, 1'b1);
    chk("st0_pc",   pc_out,    32'h8000_0000);
    chk("st0_inst", inst_out,  32'h1111);
    chk("st0_cnt",  count,     2'd1);
    offer(1'b1, 32'h8000_0004, 32'h2222);
    step();
    chk("st1_pc",   pc_out,    32'h8000_0004);
    chk("st1_inst", inst_out,  32'h2222);
    chk("st1_cnt",  count,     2'd1);
    offer(1'b1, 32'h8000_0008, 32'h3333);
    step();
    chk("st2_pc",   pc_out,    32'h8000_0008);
    chk("st2_cnt",  count,     2'd1);
    chk("st2_rdy",  in_ready,  1'b1);
    offer(1'b0, 32'h0, 32'h0);
    step();
    chk("st_drain_vld",  out_valid, 1'b0);
    chk("st_drain_inst", inst_out,  32'h0);
    chk("st_drain_pc",   pc_out,    32'h8000_0008);
    chk("st_drain_cnt",  count,     2'd0);

    // Skid: downstream stalls for two cycles
    offer(1'b1, 32'h100, 32'hA1);
    step();
    out_ready = 1'b0;
    offer(1'b1, 32'h104, 32'hB2);
    step();
    chk("sk0_cnt", count,    2'd2);
    chk("sk0_rdy", in_ready, 1'b0);
    chk("sk0_pc",  pc_out,   32'h100);
    offer(1'b1, 32'h108, 32'hC3);
    step();
    chk("sk1_cnt",  count,    2'd2);
    chk("sk1_rdy",  in_ready, 1'b0);
    chk("sk1_inst", inst_out, 32'hA1);
    out_ready = 1'b1;
    step();
    chk("sk2_pc",   pc_out,   32'h104);
    chk("sk2_inst", inst_out, 32'hB2);
    chk("sk2_cnt",  count,    2'd1);
    chk("sk2_rdy",  in_ready, 1'b1);
    step();
    chk("sk3_pc",   pc_out,   32'h108);
    chk("sk3_inst", inst_out, 32'hC3);
    offer(1'b0, 32'h0, 32'h0);
    step();
    chk("sk4_vld", out_valid, 1'b0);
    chk("sk4_cnt", count,     2'd0);

    // Flush while FULL, stalled, with a same-cycle offer
    out_ready = 1'b0;
    offer(1'b1, 32'h200, 32'hD4);
    step();
    offer(1'b1, 32'h204, 32'hE5);
    step();
    chk("fl_pre_cnt", count, 2'd2);
    flush = 1'b1;
    offer(1'b1, 32'h208, 32'hF6);
    step();
    chk("fl_vld",   out_valid,     1'b0);
    chk("fl_inst",  inst_out,      32'h0);
    chk("fl_pc",    pc_out,        32'h200);
    chk("fl_cnt",   count,         2'd0);
    chk("fl_rdy",   in_ready,      1'b1);
    chk("fl_drops", flush_drops,   8'd2);
    chk("fl_sat",   s_flush_drops, 2'd2);
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    step();
    chk("fl_nocap_vld", out_valid, 1'b0);
    chk("fl_nocap_cnt", count,     2'd0);

    // Flush in ONE with a simultaneous out-fire
    out_ready = 1'b1;
    offer(1'b1, 32'h300, 32'h77);
    step();
    chk("fo_pre_cnt", count, 2'd1);
    flush = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    step();
    chk("fo_drops", flush_drops,   8'd2);
    chk("fo_sat",   s_flush_drops, 2'd2);
    chk("fo_cnt",   count,         2'd0);
    chk("fo_vld",   out_valid,     1'b0);
    flush = 1'b0;

    // Saturation: the 2-bit counter sticks at 3
    for (int r = 0; r < 2; r++) begin
      out_ready = 1'b0;
      offer(1'b1, 32'h400 + 32'(r * 8), 32'h500 + 32'(r));
      step();
      offer(1'b1, 32'h404 + 32'(r * 8), 32'h600 + 32'(r));
      step();
      chk("sat_full_cnt", s_count, 2'd2);
      flush = 1'b1;
      offer(1'b0, 32'h0, 32'h0);
      step();
      flush = 1'b0;
      chk("sat_drops8", flush_drops,   8'(4 + 2 * r));
      chk("sat_drops2", s_flush_drops, 2'd3);
    end

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    offer(1'b1, 32'h900, 32'h99);
    step();
    chk("ar_pre_vld", out_valid, 1'b1);
    offer(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc",    pc_out,      32'h8000_0000);
    chk("ar_inst",  inst_out,    32'h0);
    chk("ar_vld",   out_valid,   1'b0);
    chk("ar_rdy",   in_ready,    1'b1);
    chk("ar_cnt",   count,       2'd0);
    chk("ar_drops", flush_drops, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_vld", out_valid, 1'b0);
    chk("ar_post_cnt", count,     2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppl_stage_buf.md
# ppl_stage_buf

Parametrised elastic pipeline stage register with a two-entry skid buffer, carrying a PC and instruction word between pipeline stages, typically fetch→decode. It decouples stage stalls via a valid/ready handshake. It provides a flush that inserts a bubble, and a NOP instruction on every empty slot. `inReady` is registered, so there is no combinational path from `outReady` to `inReady`.

## Interface
- `PC_W`, 32, PC field width
- `INST_W`, 32, instruction field width
- `RESET_PC`, 32'h8000_0000, value of `pcOut` after reset
- `NOP_INST`, 0, value driven on `instOut` whenever `outValid`=0
- `FLUSH_CNT_W`, 8, width of the flush-drop counter

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared immediately on assertion
- `flush`  in  1  synchronous; discard all held entries
- `inValid`  in  1  upstream offers `pcIn`/`instIn`
- `inReady`  out  1  stage can accept; registered
- `pcIn`  in  PC_W  incoming PC
- `instIn`  in  INST_W  incoming instruction
- `outValid`  out  1  `pcOut`/`instOut` hold a live entry
- `outReady`  in  1  downstream accepts this cycle
- `pcOut`  out  PC_W  head-entry PC
- `instOut`  out  INST_W  head-entry instruction, or `NOP_INST`
- `count`  out  2  entries held (0..2)
- `flushDrops`  out  FLUSH_CNT_W  saturating total of live entries discarded by flush

## Operation
- Definitions:
  - in-fire = `inValid` & `inReady`
  - out-fire = `outValid` & `outReady`
- Storage:
  - main register drives the outputs
  - skid register holds one overflow entry
- Three states:
  - EMPTY (count 0)
  - ONE (main live)
  - FULL (main and skid live)
- `inReady` = (state != FULL).
- `outValid` = (state != EMPTY).
- EMPTY:
  - in-fire → ONE, main ← in
- ONE:
  - in-fire & out-fire → ONE, main ← in
  - in-fire only → FULL, skid ← in
  - out-fire only → EMPTY
  - neither → hold
- FULL:
  - out-fire → ONE, main ← skid
  - otherwise hold
  - `inValid` is ignored
- Ordering is strict FIFO; no entry is duplicated or lost except by flush.
- `flush` has highest priority:
  - next state EMPTY; `instOut` ← `NOP_INST`; `pcOut` holds its value
  - `pcIn`/`instIn` offered that cycle are not captured
  - an out-fire in the same cycle still counts as delivered, and is not added to `flushDrops`
- `flushDrops` adds the number of live entries discarded (count, minus 1 if out-fire that cycle) and saturates at all-ones.
- On any transition into EMPTY (out-fire or flush), `instOut` ← `NOP_INST` and `pcOut` holds.
- Reset values:
  - state EMPTY, `outValid`=0, `inReady`=1, `count`=0
  - `pcOut`=`RESET_PC`, `instOut`=`NOP_INST`, `flushDrops`=0
  - skid contents are don't-care but must not be visible
- Reset asserted mid-operation drops all entries at once; `flushDrops` is not incremented.

## Timing
- Latency:
  - in-fire at edge N → `outValid`=1 with that data after edge N, visible in cycle N+1
  - zero bubbles at full throughput
- Sustained throughput is one entry per cycle while `outReady`=1.
- One downstream stall cycle is absorbed by the skid register. `inReady` falls in the cycle after the stall causes FULL.
- `inReady`, `outValid`, `count`, `pcOut`, `instOut` and `flushDrops` are all direct register outputs, with no combinational input→output paths.
- Upstream must hold `inValid`/data stable until in-fire; `pcOut`/`instOut` are stable while `outValid` & !`outReady`.

## Test plan
- Reset:
  - stimulus: assert `reset`=0 mid-stream, then release
  - required: `pcOut`=32'h8000_0000, `instOut`=0, `outValid`=0, `inReady`=1, `count`=0; asynchronous, before next edge
- Streaming:
  - stimulus: `outReady`=1, feed PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles
  - required: appear on `pcOut` one cycle later each, no gaps, `count` stays 1
- Skid:
  - stimulus: stream with `outReady`=0 for 2 cycles
  - required: `count` reaches 2, `inReady`=0 for exactly the FULL cycles; on release, order preserved, no loss or duplicate
- Flush while FULL with `outReady`=0:
  - required: next cycle `outValid`=0, `instOut`=`NOP_INST`, `count`=0, `flushDrops`+=2
  - same-cycle `pcIn` is not captured
- Flush with simultaneous out-fire in ONE:
  - required: entry counted as delivered, `flushDrops` unchanged
- Saturation (`FLUSH_CNT_W`=2):
  - stimulus: repeated flushes of FULL
  - required: `flushDrops` sticks at 3
